// File: rtl/msrv32_store_unit_hs.sv
// Data-memory write port controller: formats RV32 byte/half/word stores into a
// word-aligned masked bus write and runs a req/ack handshake with a timeout.
module msrv32_store_unit_hs #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        mem_wr_req_in,
   input  logic [1:0]  store_size_in,
   input  logic [31:0] iadder_in,
   input  logic [31:0] rs2_in,
   input  logic        d_ack_in,
   output logic        d_wr_req_out,
   output logic [31:0] d_addr_out,
   output logic [31:0] d_data_out,
   output logic [3:0]  d_wr_mask_out,
   output logic        stall_out,
   output logic        bus_err_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_ERR  = 2'b10
   } state_t;

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q,   state_d;
   logic [TO_W-1:0]  cnt_q,     cnt_d;
   logic             wr_req_q,  wr_req_d;
   logic [31:0]      addr_q,    addr_d;
   logic [31:0]      data_q,    data_d;
   logic [3:0]       mask_q,    mask_d;
   logic             bus_err_q, bus_err_d;

   function automatic logic [31:0] fmt_data(input logic [1:0] size, input logic [31:0] rs2);
      logic [31:0] res;
      case (size)
         2'b00:   res = {4{rs2[7:0]}};
         2'b01:   res = {2{rs2[15:0]}};
         default: res = rs2;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] fmt_mask(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] res;
      case (size)
         2'b00:   res = 4'b0001 << a;
         2'b01:   res = a[1] ? 4'b1100 : 4'b0011;
         default: res = 4'b1111;
      endcase
      return res;
   endfunction

   // Next-state and registered-output next values; payload is held outside capture.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_req_d  = wr_req_q;
      addr_d    = addr_q;
      data_d    = data_q;
      mask_d    = mask_q;
      bus_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_wr_req_in) begin
               state_d  = ST_REQ;
               cnt_d    = {TO_W{1'b0}};
               wr_req_d = 1'b1;
               addr_d   = {iadder_in[31:2], 2'b00};
               data_d   = fmt_data(store_size_in, rs2_in);
               mask_d   = fmt_mask(store_size_in, iadder_in[1:0]);
            end else begin
               wr_req_d = 1'b0;
            end
         end
         ST_REQ: begin
            // Ack has priority over a timeout expiring in the same cycle.
            if (d_ack_in) begin
               state_d  = ST_IDLE;
               wr_req_d = 1'b0;
            end else if (cnt_q == TO_LIMIT) begin
               state_d   = ST_ERR;
               wr_req_d  = 1'b0;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
            end
         end
         ST_ERR: begin
            state_d  = ST_IDLE;
            wr_req_d = 1'b0;
         end
         default: begin
            state_d  = ST_IDLE;
            wr_req_d = 1'b0;
         end
      endcase
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {TO_W{1'b0}};
         wr_req_q  <= 1'b0;
         addr_q    <= 32'h0000_0000;
         data_q    <= 32'h0000_0000;
         mask_q    <= 4'b0000;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_req_q  <= wr_req_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         mask_q    <= mask_d;
         bus_err_q <= bus_err_d;
      end
   end

   // The pipeline is released in the ack cycle itself so no instruction issues twice.
   always_comb begin
      stall_out = ((state_q == ST_IDLE) & mem_wr_req_in) |
                  ((state_q == ST_REQ)  & ~d_ack_in);
   end

   assign d_wr_req_out  = wr_req_q;
   assign d_addr_out    = addr_q;
   assign d_data_out    = data_q;
   assign d_wr_mask_out = mask_q;
   assign bus_err_out   = bus_err_q;

endmodule

// File: tb/tb_msrv32_store_unit_hs.sv
// Randomized self-checking bench for msrv32_store_unit_hs against a
// transaction-level model of store formatting and handshake timing.
module tb_msrv32_store_unit_hs;

   localparam int TO = 4;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        mem_wr_req_in;
   logic [1:0]  store_size_in;
   logic [31:0] iadder_in;
   logic [31:0] rs2_in;
   logic        d_ack_in;
   logic        d_wr_req_out;
   logic [31:0] d_addr_out;
   logic [31:0] d_data_out;
   logic [3:0]  d_wr_mask_out;
   logic        stall_out;
   logic        bus_err_out;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk_in = ~clk_in;

   msrv32_store_unit_hs #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .mem_wr_req_in (mem_wr_req_in),
      .store_size_in (store_size_in),
      .iadder_in     (iadder_in),
      .rs2_in        (rs2_in),
      .d_ack_in      (d_ack_in),
      .d_wr_req_out  (d_wr_req_out),
      .d_addr_out    (d_addr_out),
      .d_data_out    (d_data_out),
      .d_wr_mask_out (d_wr_mask_out),
      .stall_out     (stall_out),
      .bus_err_out   (bus_err_out)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: lane replication by multiplication, mask from byte offset.
   function automatic logic [31:0] model_data(input int size, input logic [31:0] rs2);
      if (size == 0)      return (rs2 & 32'h0000_00FF) * 32'h0101_0101;
      else if (size == 1) return (rs2 & 32'h0000_FFFF) * 32'h0001_0001;
      else                return rs2;
   endfunction

   function automatic logic [31:0] model_mask(input int size, input logic [31:0] addr);
      int off;
      off = int'(addr % 32'd4);
      if (size == 0)      return 32'(1 << off);
      else if (size == 1) return (off >= 2) ? 32'hC : 32'h3;
      else                return 32'hF;
   endfunction

   task automatic next_cycle();
      @(posedge clk_in);
      #1;
   endtask

   // One store; ack arrives in REQ cycle ack_at (1-based), beyond TO means never.
   task automatic run_store(input int size, input logic [31:0] addr, input logic [31:0] data,
                            input int ack_at);
      int          nreq;
      bit          err;
      logic [31:0] ea, ed, em;
      nreq = (ack_at <= TO) ? ack_at : TO;
      err  = (ack_at > TO);
      ea   = addr - (addr % 32'd4);
      ed   = model_data(size, data);
      em   = model_mask(size, addr);
      mem_wr_req_in = 1'b1;
      store_size_in = 2'(size);
      iadder_in     = addr;
      rs2_in        = data;
      d_ack_in      = 1'b0;
      @(negedge clk_in);
      check_eq("stall_issue", stall_out, 1);
      check_eq("req_before_issue", d_wr_req_out, 0);
      next_cycle();
      for (int k = 1; k <= nreq; k++) begin
         mem_wr_req_in = 1'($urandom);
         store_size_in = 2'($urandom);
         iadder_in     = $urandom;
         rs2_in        = $urandom;
         d_ack_in      = (k == ack_at);
         @(negedge clk_in);
         check_eq("req_hold", d_wr_req_out, 1);
         check_eq("addr", d_addr_out, ea);
         check_eq("data", d_data_out, ed);
         check_eq("mask", d_wr_mask_out, em);
         check_eq("no_err_in_req", bus_err_out, 0);
         check_eq("stall_req", stall_out, (k == ack_at) ? 1'b0 : 1'b1);
         next_cycle();
      end
      mem_wr_req_in = 1'b0;
      d_ack_in      = 1'($urandom);
      @(negedge clk_in);
      check_eq("req_after", d_wr_req_out, 0);
      check_eq("bus_err", bus_err_out, err);
      check_eq("stall_after", stall_out, 0);
      if (err) begin
         next_cycle();
         d_ack_in = 1'b0;
         @(negedge clk_in);
         check_eq("err_one_cycle", bus_err_out, 0);
         check_eq("req_after_err", d_wr_req_out, 0);
      end
      d_ack_in = 1'b0;
      next_cycle();
   endtask

   initial begin
      rst_in        = 1'b1;
      mem_wr_req_in = 1'b0;
      store_size_in = 2'b00;
      iadder_in     = 32'h0;
      rs2_in        = 32'h0;
      d_ack_in      = 1'b0;
      next_cycle();
      next_cycle();
      rst_in = 1'b0;
      @(negedge clk_in);
      check_eq("rst_req", d_wr_req_out, 0);
      check_eq("rst_addr", d_addr_out, 0);
      check_eq("rst_data", d_data_out, 0);
      check_eq("rst_mask", d_wr_mask_out, 0);
      check_eq("rst_err", bus_err_out, 0);
      check_eq("rst_stall", stall_out, 0);
      next_cycle();

      run_store(0, 32'h0000_1003, 32'hAABB_CCDD, 1);
      run_store(1, 32'h0000_2002, 32'h1234_5678, 3);
      run_store(2, 32'h0000_0040, 32'hCAFE_F00D, 2);
      run_store(3, 32'h0000_0081, 32'h0BAD_BEEF, 1);
      run_store(2, 32'h0000_0100, 32'h1111_2222, TO + 10);
      run_store(0, 32'h0000_0101, 32'h0000_0077, TO);

      // Stray ack in IDLE must not start anything.
      d_ack_in = 1'b1;
      @(negedge clk_in);
      check_eq("stray_ack_stall", stall_out, 0);
      next_cycle();
      d_ack_in = 1'b0;
      @(negedge clk_in);
      check_eq("stray_ack_req", d_wr_req_out, 0);
      check_eq("stray_ack_err", bus_err_out, 0);
      next_cycle();

      // Reset in the middle of an outstanding write.
      mem_wr_req_in = 1'b1;
      store_size_in = 2'b10;
      iadder_in     = 32'h0000_0200;
      rs2_in        = 32'h5555_AAAA;
      next_cycle();
      mem_wr_req_in = 1'b0;
      next_cycle();
      @(negedge clk_in);
      check_eq("midreq_req", d_wr_req_out, 1);
      rst_in = 1'b1;
      next_cycle();
      @(negedge clk_in);
      check_eq("midrst_req", d_wr_req_out, 0);
      next_cycle();
      rst_in = 1'b0;
      @(negedge clk_in);
      check_eq("midrst_req2", d_wr_req_out, 0);
      check_eq("midrst_addr", d_addr_out, 0);
      check_eq("midrst_data", d_data_out, 0);
      check_eq("midrst_mask", d_wr_mask_out, 0);
      check_eq("midrst_err", bus_err_out, 0);
      check_eq("midrst_stall", stall_out, 0);
      next_cycle();
      run_store(1, 32'h0000_3000, 32'h9876_5432, 2);

      for (int i = 0; i < 300; i++) begin
         run_store(int'($urandom_range(0, 3)), $urandom, $urandom,
                   int'($urandom_range(1, TO + 2)));
         if ($urandom_range(0, 3) == 0) begin
            mem_wr_req_in = 1'b0;
            d_ack_in      = 1'($urandom);
            @(negedge clk_in);
            check_eq("idle_gap_stall", stall_out, 0);
            next_cycle();
            d_ack_in = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
